// File: rtl/ov7670_pkg.sv
// Shared OV7670 capture definitions: capture FSM states, default frame geometry
// and the frame-buffer address width also used by the display side.
package ov7670_pkg;

  localparam int unsigned H_REZ_DEF = 640;
  localparam int unsigned V_REZ_DEF = 480;
  localparam int unsigned ADDR_W    = 19;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_VS_HIGH = 2'd1,
    ST_WAIT_VS_LOW  = 2'd2,
    ST_ACTIVE       = 2'd3
  } cap_state_e;

endpackage

// File: rtl/cam_edge_det.sv
// Registers one camera control input and flags its rising and falling edges,
// with both edges taken from the registered copy.
module cam_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise_c,
  output logic fall_c
);

  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    sync_d = din;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout   = sync_q;
  assign rise_c = sync_q & ~prev_q;
  assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 YUYV capture: frames are synchronised on vsync, and each Y byte is
// written to a raster-ordered frame buffer as a 4-bit grey pixel.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned hRez = H_REZ_DEF,
  parameter int unsigned vRez = V_REZ_DEF
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic [18:0]       frame_addr,
  output logic [3:0]        frame_pixel,
  output logic              frame_we,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned COL_W = $clog2(hRez + 1);
  localparam int unsigned ROW_W = $clog2(vRez + 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(hRez * vRez - 1);
  localparam logic [ADDR_W-1:0] H_ADDR   = ADDR_W'(hRez);
  localparam logic [COL_W-1:0]  H_COL    = COL_W'(hRez);
  localparam logic [ROW_W-1:0]  V_ROW    = ROW_W'(vRez);
  localparam logic [ROW_W-1:0]  V_LAST   = ROW_W'(vRez - 1);

  logic vs_s, vs_rise_c, vs_fall_c;
  logic hr_s, hr_rise_c, hr_fall_c;
  logic cur_phase_c;

  cap_state_e        state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              phase_q, phase_d;
  logic [7:0]        y_q, y_d;
  logic [3:0]        pixel_q, pixel_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  cam_edge_det u_vs_edge (
    .clk    (pclk),
    .rst    (rst),
    .din    (cam_vsync),
    .dout   (vs_s),
    .rise_c (vs_rise_c),
    .fall_c (vs_fall_c)
  );

  cam_edge_det u_hr_edge (
    .clk    (pclk),
    .rst    (rst),
    .din    (cam_href),
    .dout   (hr_s),
    .rise_c (hr_rise_c),
    .fall_c (hr_fall_c)
  );

  // The first byte of every line is a Y byte, whatever phase was left behind.
  assign cur_phase_c = hr_rise_c ? 1'b0 : phase_q;

  always_comb begin
    state_d = state_q;
    data_d  = cam_data;
    addr_d  = addr_q;
    base_d  = base_q;
    col_d   = col_q;
    row_d   = row_q;
    phase_d = phase_q;
    y_d     = y_q;
    pixel_d = pixel_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (capture_en) state_d = ST_WAIT_VS_HIGH;
      end
      ST_WAIT_VS_HIGH: begin
        if (vs_s) state_d = ST_WAIT_VS_LOW;
      end
      ST_WAIT_VS_LOW: begin
        if (vs_fall_c) begin
          state_d = ST_ACTIVE;
          addr_d  = '0;
          base_d  = '0;
          col_d   = '0;
          row_d   = '0;
          phase_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_ACTIVE: begin
        // Advance past the pixel written last cycle, pinned at the last cell.
        if (we_q && (addr_q != MAX_ADDR)) addr_d = addr_q + ADDR_W'(1);

        if (vs_rise_c) begin
          done_d  = 1'b1;
          if (row_q < V_ROW) err_d = 1'b1;
          state_d = capture_en ? ST_WAIT_VS_LOW : ST_IDLE;
        end else if (hr_fall_c) begin
          phase_d = 1'b0;
          col_d   = '0;
          if (row_q < V_ROW) begin
            if (col_q != H_COL) err_d = 1'b1;
            row_d = row_q + ROW_W'(1);
          end
          // Row start tracked by accumulation; realigns after short lines too.
          if (row_q < V_LAST) begin
            base_d = base_q + H_ADDR;
            addr_d = base_q + H_ADDR;
          end
        end else if (hr_s) begin
          phase_d = ~cur_phase_c;
          if (!cur_phase_c) begin
            y_d = data_q;
          end else if ((col_q < H_COL) && (row_q < V_ROW)) begin
            we_d    = 1'b1;
            pixel_d = y_q[7:4];
            col_d   = col_q + COL_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      base_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= 1'b0;
      y_q     <= '0;
      pixel_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      y_q     <= y_d;
      pixel_q <= pixel_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign frame_addr  = addr_q;
  assign frame_pixel = pixel_q;
  assign frame_we    = we_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 The block SHALL have parameter hRez, default 640, meaning pixels per active line.
REQ-002 The block SHALL have parameter vRez, default 480, meaning active lines per frame.
REQ-003 The block SHALL have port pclk, input, 1 bit: camera pixel clock and sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port cam_vsync, input, 1 bit: camera frame sync, high between frames.
REQ-006 The block SHALL have port cam_href, input, 1 bit: camera line-valid, high while line bytes are present.
REQ-007 The block SHALL have port cam_data, input, 8 bits: camera byte bus, YUYV order (even byte Y, odd byte U/V).
REQ-008 The block SHALL have port capture_en, input, 1 bit: enables capture of the next frame; low freezes the buffer.
REQ-009 The block SHALL have port frame_addr, output, 19 bits: frame-buffer write address, raster order, row*hRez+col.
REQ-010 The block SHALL have port frame_pixel, output, 4 bits: grey write data, equal to Y[7:4].
REQ-011 The block SHALL have port frame_we, output, 1 bit: frame-buffer write strobe, one cycle per pixel.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each captured frame.
REQ-013 The block SHALL have port frame_err, output, 1 bit: sticky error for the current frame (short, long or extra line).

Function
REQ-014 The block SHALL register cam_vsync, cam_href and cam_data once on entry; all edge detection uses the registered copies.
REQ-015 The block SHALL implement FSM states IDLE, WAIT_VS_HIGH, WAIT_VS_LOW and ACTIVE.
REQ-016 The FSM SHALL move IDLE->WAIT_VS_HIGH when capture_en=1, WAIT_VS_HIGH->WAIT_VS_LOW on vsync=1, WAIT_VS_LOW->ACTIVE on the vsync falling edge, and ACTIVE->(WAIT_VS_LOW if capture_en=1, else IDLE) on the vsync rising edge.
REQ-017 On ACTIVE entry the block SHALL clear the pixel address, column, row, byte phase and frame_err.
REQ-018 In ACTIVE with href=1, the block SHALL toggle the byte phase each cycle, latch Y on phase 0, and on phase 1 issue one write.
REQ-019 Each write SHALL assert frame_we for exactly one cycle, one cycle after the phase-1 byte is sampled, with the current frame_addr and frame_pixel=Y[7:4]; frame_addr then increments by 1.
REQ-020 On the href falling edge the block SHALL increment the row, reset column and phase, and set frame_addr=row*hRez using an adder, not a multiplier.
REQ-021 A line shorter than hRez pixels SHALL set frame_err; the address SHALL still realign to the next row start.
REQ-022 Pixels beyond column hRez-1 or rows beyond vRez-1 SHALL NOT be written, SHALL set frame_err, and frame_addr SHALL never exceed hRez*vRez-1.
REQ-023 When href falls with phase=1, the half pixel SHALL be discarded without a write.
REQ-024 When vsync rises mid-line, the line SHALL be aborted, frame_done SHALL pulse, and frame_err SHALL be set if the row count is below vRez.
REQ-025 frame_done SHALL pulse one cycle after the vsync rising edge in ACTIVE, regardless of frame_err.
REQ-026 capture_en falling during ACTIVE SHALL NOT truncate the frame; the frame completes, then the FSM enters IDLE.
REQ-027 frame_we SHALL be 0 in every state other than ACTIVE.

Reset
REQ-028 While rst=1 the block SHALL hold state IDLE, with frame_addr=0, frame_pixel=0, frame_we=0, frame_done=0, frame_err=0, and the input registers cleared.
REQ-029 Reset asserted mid-frame SHALL abort immediately; after release, capture SHALL resume only at the next full vsync high->low sequence.

Structure
REQ-030 Package ov7670_pkg SHALL hold the FSM state enum, the default hRez/vRez constants and the 19-bit address width constant, shared with the display side.
REQ-031 Sub-module cam_edge_det SHALL provide a registered input plus rise/fall pulses, instantiated for vsync and href; all other logic stays in ov7670_capture.

Verification
REQ-032 Full 640x480 frame, Y byte=0xA7 everywhere -> 307200 writes, pixel 0xA, last addr 307199, one frame_done, frame_err=0.
REQ-033 Line 5 carries 600 pixels -> frame_err=1; the first write of line 6 goes to addr 3840.
REQ-034 Line 0 carries 650 pixels -> only 640 writes, frame_err=1, line 1 starts at addr 640.
REQ-035 vsync rises during row 100 -> line aborted, frame_done pulses, frame_err=1, no further writes.
REQ-036 capture_en dropped at row 200 -> frame finishes to addr 307199, FSM enters IDLE, zero writes on the next frame.
REQ-037 rst pulsed at row 50 -> outputs zero immediately; the remainder of that frame produces no writes, and the next frame starts at addr 0.
